// File: rtl/pu_sequencer.sv
// Program-memory sequencer: steps through a loaded control-word program,
// driving each word onto a registered control bus with stall, jump and stop handling.
module pu_sequencer #(
  parameter int PROGRAM_SIZE     = 200,
  parameter int INSTRUCTION_SIZE = 16,
  parameter int PC_WIDTH         = $clog2(PROGRAM_SIZE)
) (
  input  logic                        pu_clk,
  input  logic                        pu_rst,
  input  logic                        pu_load_we,
  input  logic [PC_WIDTH-1:0]         pu_load_addr,
  input  logic [INSTRUCTION_SIZE-1:0] pu_load_data,
  input  logic [PC_WIDTH-1:0]         pu_last_addr,
  input  logic                        pu_start,
  input  logic                        pu_stop,
  input  logic                        pu_stall,
  input  logic                        pu_jump,
  output logic [INSTRUCTION_SIZE-1:0] pu_control_bus,
  output logic [PC_WIDTH-1:0]         pu_pc,
  output logic                        pu_cycle_end,
  output logic [15:0]                 pu_cycle_count,
  output logic                        pu_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [PC_WIDTH-1:0] LAST_MAX = PC_WIDTH'(PROGRAM_SIZE - 1);
  localparam logic [PC_WIDTH:0]   SIZE_W   = (PC_WIDTH + 1)'(PROGRAM_SIZE);

  logic [INSTRUCTION_SIZE-1:0] mem_r [PROGRAM_SIZE];

  state_t                      state_r, state_s;
  state_t                      origin_r, origin_s;
  state_t                      mode_s;
  logic [PC_WIDTH-1:0]         pc_r, pc_s;
  logic [PC_WIDTH-1:0]         last_r, last_s;
  logic [INSTRUCTION_SIZE-1:0] bus_r, bus_s;
  logic [15:0]                 count_r, count_s;
  logic                        end_r, end_s;
  logic                        busy_r;
  logic                        pend_r, pend_s;
  logic                        load_ok_s;

  assign load_ok_s = pu_load_we && (state_r == IDLE) && ({1'b0, pu_load_addr} < SIZE_W);

  // Program memory write port; contents deliberately survive reset.
  always_ff @(posedge pu_clk) begin
    if (load_ok_s) begin
      mem_r[pu_load_addr] <= pu_load_data;
    end
  end

  // Next-state, next-pc and cycle accounting; HOLD resumes with its origin's behaviour.
  always_comb begin
    state_s  = state_r;
    origin_s = origin_r;
    pc_s     = pc_r;
    last_s   = last_r;
    count_s  = count_r;
    end_s    = 1'b0;
    pend_s   = pend_r;
    mode_s   = (state_r == HOLD) ? origin_r : state_r;
    case (state_r)
      IDLE: begin
        pc_s = {PC_WIDTH{1'b0}};
        if (pu_start && !pu_stop) begin
          state_s = RUN;
          last_s  = (pu_last_addr > LAST_MAX) ? LAST_MAX : pu_last_addr;
          count_s = 16'd0;
          pend_s  = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      RUN, FINISH, HOLD: begin
        if (pu_stall) begin
          state_s = HOLD;
          if (state_r != HOLD) begin
            origin_s = state_r;
          end else begin
            origin_s = origin_r;
          end
          pend_s = pend_r | pu_jump;
        end else begin
          if (pu_jump || pend_r) begin
            pend_s = 1'b0;
            pc_s   = {PC_WIDTH{1'b0}};
          end else if (pc_r == last_r) begin
            pc_s    = {PC_WIDTH{1'b0}};
            end_s   = 1'b1;
            count_s = count_r + 16'd1;
          end else begin
            pc_s = pc_r + PC_WIDTH'(1'b1);
          end
          // FINISH retires to IDLE on wrap or jump; a plain advance keeps it finishing.
          if (mode_s == FINISH) begin
            if (pu_jump || pend_r || end_s) begin
              state_s = IDLE;
              pc_s    = {PC_WIDTH{1'b0}};
            end else begin
              state_s = FINISH;
            end
          end else if (pu_stop) begin
            state_s = FINISH;
          end else begin
            state_s = RUN;
          end
        end
      end
      default: begin
        state_s = IDLE;
        pc_s    = {PC_WIDTH{1'b0}};
      end
    endcase
    bus_s = (state_s == IDLE) ? {INSTRUCTION_SIZE{1'b0}} : mem_r[pc_s];
  end

  // State and registered outputs.
  always_ff @(posedge pu_clk or negedge pu_rst) begin
    if (!pu_rst) begin
      state_r  <= IDLE;
      origin_r <= RUN;
      pc_r     <= {PC_WIDTH{1'b0}};
      last_r   <= {PC_WIDTH{1'b0}};
      bus_r    <= {INSTRUCTION_SIZE{1'b0}};
      count_r  <= 16'd0;
      end_r    <= 1'b0;
      busy_r   <= 1'b0;
      pend_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      origin_r <= origin_s;
      pc_r     <= pc_s;
      last_r   <= last_s;
      bus_r    <= bus_s;
      count_r  <= count_s;
      end_r    <= end_s;
      busy_r   <= (state_s != IDLE);
      pend_r   <= pend_s;
    end
  end

  assign pu_control_bus = bus_r;
  assign pu_pc          = pc_r;
  assign pu_cycle_end   = end_r;
  assign pu_cycle_count = count_r;
  assign pu_busy        = busy_r;

endmodule

// File: tb/tb_pu_sequencer.sv
// Directed bench for pu_sequencer: program load, wrap, stall/jump, stop,
// ignored RUN writes, async reset, address clamping and single-word programs.
module tb_pu_sequencer;

  localparam int PS = 200;
  localparam int IW = 16;
  localparam int PW = $clog2(PS);

  logic          pu_clk;
  logic          pu_rst;
  logic          pu_load_we;
  logic [PW-1:0] pu_load_addr;
  logic [IW-1:0] pu_load_data;
  logic [PW-1:0] pu_last_addr;
  logic          pu_start;
  logic          pu_stop;
  logic          pu_stall;
  logic          pu_jump;
  logic [IW-1:0] pu_control_bus;
  logic [PW-1:0] pu_pc;
  logic          pu_cycle_end;
  logic [15:0]   pu_cycle_count;
  logic          pu_busy;

  int checks = 0;
  int errors = 0;

  pu_sequencer #(.PROGRAM_SIZE(PS), .INSTRUCTION_SIZE(IW)) dut (
    .pu_clk         (pu_clk),
    .pu_rst         (pu_rst),
    .pu_load_we     (pu_load_we),
    .pu_load_addr   (pu_load_addr),
    .pu_load_data   (pu_load_data),
    .pu_last_addr   (pu_last_addr),
    .pu_start       (pu_start),
    .pu_stop        (pu_stop),
    .pu_stall       (pu_stall),
    .pu_jump        (pu_jump),
    .pu_control_bus (pu_control_bus),
    .pu_pc          (pu_pc),
    .pu_cycle_end   (pu_cycle_end),
    .pu_cycle_count (pu_cycle_count),
    .pu_busy        (pu_busy)
  );

  initial begin
    pu_clk = 1'b0;
    forever #5 pu_clk = ~pu_clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pu_clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int pc, input int bus, input int cend, input int cnt, input int busy);
    check_eq({tag, " pc"}, 32'(pu_pc), 32'(pc));
    check_eq({tag, " bus"}, 32'(pu_control_bus), 32'(bus));
    check_eq({tag, " end"}, 32'(pu_cycle_end), 32'(cend));
    check_eq({tag, " count"}, 32'(pu_cycle_count), 32'(cnt));
    check_eq({tag, " busy"}, 32'(pu_busy), 32'(busy));
  endtask

  initial begin
    pu_rst = 1'b0; pu_load_we = 1'b0; pu_load_addr = '0; pu_load_data = '0;
    pu_last_addr = '0; pu_start = 1'b0; pu_stop = 1'b0; pu_stall = 1'b0; pu_jump = 1'b0;
    #12;
    check_out("reset", 0, 0, 0, 0, 0);
    pu_rst = 1'b1;

    // program load: words 0..4, plus the top of memory for the clamp test
    for (int k = 0; k < 5; k++) begin
      pu_load_we = 1'b1; pu_load_addr = PW'(k); pu_load_data = IW'(16'h1000 + k);
      step();
    end
    pu_load_addr = 8'd199; pu_load_data = 16'hC7C7; step();
    pu_load_addr = 8'd250; pu_load_data = 16'hDEAD; step();
    pu_load_we = 1'b0;
    check_out("idle after load", 0, 0, 0, 0, 0);

    // basic sequencing and wrap
    pu_last_addr = 8'd4; pu_start = 1'b1; step(); pu_start = 1'b0;
    check_out("run k0", 0, 16'h1000, 0, 0, 1);
    for (int k = 1; k < 5; k++) begin
      step();
      check_out("run seq", k, 16'h1000 + k, 0, 0, 1);
    end
    step();
    check_out("wrap", 0, 16'h1000, 1, 1, 1);
    pu_start = 1'b1; step(); pu_start = 1'b0;
    check_out("start ignored", 1, 16'h1001, 0, 1, 1);
    step();
    check_out("pc2", 2, 16'h1002, 0, 1, 1);

    // stall for three cycles with a jump pulsed during the stall
    pu_stall = 1'b1; pu_jump = 1'b1; step(); pu_jump = 1'b0;
    check_out("stall1", 2, 16'h1002, 0, 1, 1);
    step(); check_out("stall2", 2, 16'h1002, 0, 1, 1);
    step(); check_out("stall3", 2, 16'h1002, 0, 1, 1);
    pu_stall = 1'b0; step();
    check_out("pending jump", 0, 16'h1000, 0, 1, 1);

    // writes while running are ignored
    pu_load_we = 1'b1; pu_load_addr = 8'd3; pu_load_data = 16'hFFFF; step(); pu_load_we = 1'b0;
    step(); step();
    check_out("run write ignored", 3, 16'h1003, 0, 1, 1);
    step(); step();
    check_out("wrap2", 0, 16'h1000, 1, 2, 1);
    step();

    // stop at pc=1: cycle completes, then idle
    pu_stop = 1'b1; step(); pu_stop = 1'b0;
    check_out("finish pc2", 2, 16'h1002, 0, 2, 1);
    step(); step();
    check_out("finish pc4", 4, 16'h1004, 0, 2, 1);
    step();
    check_out("finish to idle", 0, 0, 1, 3, 0);
    step();
    check_out("idle after finish", 0, 0, 0, 3, 0);

    // asynchronous reset between edges
    pu_start = 1'b1; step(); pu_start = 1'b0;
    check_out("restart", 0, 16'h1000, 0, 0, 1);
    step(); step(); step();
    check_eq("pre-reset pc", 32'(pu_pc), 32'd3);
    #2 pu_rst = 1'b0;
    #1 check_out("async reset", 0, 0, 0, 0, 0);
    #1 pu_rst = 1'b1;
    step();
    check_out("idle after reset", 0, 0, 0, 0, 0);
    pu_start = 1'b1; step(); pu_start = 1'b0;
    check_out("mem survives reset", 0, 16'h1000, 0, 0, 1);

    // jump in FINISH returns to idle without a pulse; start+stop stays idle
    pu_stop = 1'b1; step(); pu_stop = 1'b0;
    check_eq("finish busy", 32'(pu_busy), 32'd1);
    pu_jump = 1'b1; step(); pu_jump = 1'b0;
    check_out("finish jump", 0, 0, 0, 0, 0);
    pu_start = 1'b1; pu_stop = 1'b1; step(); pu_start = 1'b0; pu_stop = 1'b0;
    check_out("start with stop", 0, 0, 0, 0, 0);

    // last address clamped to PROGRAM_SIZE-1
    pu_last_addr = 8'd255; pu_start = 1'b1; step(); pu_start = 1'b0;
    for (int k = 0; k < 198; k++) step();
    check_eq("clamp pc198", 32'(pu_pc), 32'd198);
    step();
    check_out("clamp pc199", 199, 16'hC7C7, 0, 0, 1);
    step();
    check_out("clamp wrap", 0, 16'h1000, 1, 1, 1);
    pu_rst = 1'b0; step(); pu_rst = 1'b1; step();

    // single-word program: pulse every non-stalled cycle
    pu_last_addr = 8'd0; pu_start = 1'b1; step(); pu_start = 1'b0;
    check_out("last0 start", 0, 16'h1000, 0, 0, 1);
    step(); check_out("last0 c1", 0, 16'h1000, 1, 1, 1);
    step(); check_out("last0 c2", 0, 16'h1000, 1, 2, 1);
    pu_stall = 1'b1; step(); pu_stall = 1'b0;
    check_out("last0 stall", 0, 16'h1000, 0, 2, 1);
    step(); check_out("last0 resume", 0, 16'h1000, 1, 3, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pu_sequencer.md
PU_SEQUENCER -- requirements
Module: pu_sequencer

Interface
REQ-001 Parameter PROGRAM_SIZE, default 200, number of program memory words.
REQ-002 Parameter INSTRUCTION_SIZE, default 16, width of one control word.
REQ-003 Parameter PC_WIDTH, default $clog2(PROGRAM_SIZE), program counter width.
REQ-004 pu_clk  in  1  single clock; all state changes on its rising edge.
REQ-005 pu_rst  in  1  reset; asynchronous, active-low.
REQ-006 pu_load_we  in  1  program memory write strobe.
REQ-007 pu_load_addr  in  PC_WIDTH  program memory write address.
REQ-008 pu_load_data  in  INSTRUCTION_SIZE  program memory write data.
REQ-009 pu_last_addr  in  PC_WIDTH  last program address of the computational cycle; sampled on start.
REQ-010 pu_start  in  1  start request, level-sampled.
REQ-011 pu_stop  in  1  stop request; current cycle completes first.
REQ-012 pu_stall  in  1  freeze program counter and control bus.
REQ-013 pu_jump  in  1  restart computational cycle at address 0.
REQ-014 pu_control_bus  out  INSTRUCTION_SIZE  current control word to processing units.
REQ-015 pu_pc  out  PC_WIDTH  address of the word on pu_control_bus.
REQ-016 pu_cycle_end  out  1  one-cycle pulse when the word at last address is retired.
REQ-017 pu_cycle_count  out  16  completed computational cycles since start, wraps mod 2^16.
REQ-018 pu_busy  out  1  high in every state except IDLE.

Function
REQ-019 States: IDLE, RUN, HOLD, FINISH; exactly one active.
REQ-020 IDLE: pu_control_bus = 0 (NOP), pu_pc = 0, pu_busy = 0.
REQ-021 IDLE, pu_load_we=1: mem[pu_load_addr] <= pu_load_data; writes in any other state are ignored; addresses >= PROGRAM_SIZE ignored.
REQ-022 IDLE, pu_start=1, pu_stop=0: latch last = min(pu_last_addr, PROGRAM_SIZE-1), clear pu_cycle_count, go RUN; next edge pu_pc=0, pu_control_bus=mem[0].
REQ-023 IDLE with pu_start=1 and pu_stop=1: remain IDLE.
REQ-024 pu_control_bus is registered and always equals mem[pu_pc] in RUN/HOLD/FINISH; no combinational path from inputs to outputs.
REQ-025 RUN, no stall/jump: pu_pc advances by 1 per cycle; at pu_pc==last it wraps to 0.
REQ-026 Wrap: pu_cycle_end=1 for exactly the cycle pu_pc shows 0 after wrap; pu_cycle_count increments on the same edge.
REQ-027 pu_stall=1 in RUN or FINISH: go HOLD (remembering origin), pu_pc, pu_control_bus, pu_cycle_count held; pu_cycle_end=0.
REQ-028 HOLD, pu_stall=0: return to origin state and resume advancing on that edge.
REQ-029 pu_jump=1 without stall: next pu_pc=0, pu_control_bus=mem[0]; no pu_cycle_end, no count increment.
REQ-030 pu_jump=1 with pu_stall=1: jump latched pending; applied on first non-stalled edge; pending cleared then.
REQ-031 pu_stop=1 in RUN: go FINISH; sequencing continues unchanged until wrap.
REQ-032 FINISH at wrap edge: go IDLE (bus 0, pc 0), pu_cycle_end pulses, count increments; pu_jump in FINISH goes IDLE immediately, no pulse.
REQ-033 pu_start ignored while pu_busy=1.
REQ-034 last==0: pu_pc stays 0, pu_cycle_end pulses every non-stalled cycle.

Reset
REQ-035 pu_rst=0 forces IDLE asynchronously: pu_control_bus=0, pu_pc=0, pu_cycle_end=0, pu_cycle_count=0, pu_busy=0, pending jump cleared, last=0.
REQ-036 Program memory contents are not reset and survive pu_rst.
REQ-037 Reset asserted mid-RUN/HOLD/FINISH takes effect without waiting for a clock edge; after release, block waits in IDLE for pu_start.

Verification
REQ-038 Load mem[k]=16'h1000+k for k=0..4, last=4, start -> pu_pc 0,1,2,3,4,0,1..; bus 1000..1004; pu_cycle_end with pc=0 after 1004; count 1.
REQ-039 RUN at pc=2, stall 3 cycles with jump pulsed during stall -> pc/bus hold 2/1002 for 3 cycles, then pc=0, no cycle_end, count unchanged.
REQ-040 Stop asserted at pc=1 -> pc 2,3,4 continue, then IDLE with bus 0, busy 0, one cycle_end, count +1.
REQ-041 pu_load_we to address 3 with data 16'hFFFF during RUN -> mem[3] unchanged; bus shows 1003 at pc=3.
REQ-042 pu_rst=0 between edges at pc=3 -> bus 0, pc 0, busy 0 immediately; start after release gives bus 1000.
REQ-043 last_addr=255 with PROGRAM_SIZE=200 -> wrap occurs after pc=199; last_addr=0 -> cycle_end every cycle, count increments each cycle.
